melay_seq_n: RTL and testbench
==============================

Name: melay_seq_n

Overview:
- Parametrised N-stage Mealy sequencer; successor to the fixed three-stage start_a/b/c controller.
- On `start`, it launches the enabled sub-units one after another and waits for each unit's done before launching the next. It pulses `done` when the last enabled stage completes.
- Adds a per-run stage-skip mask, a per-stage timeout with error reporting, and synchronous abort.
- Sits between a top-level controller and N sub-units that use start-pulse/done-pulse handshakes.

Parameters:
- NUM_STAGES, 3, number of sequenced sub-units (1..16).
- TIMEOUT_CYCLES, 16, maximum wait cycles per stage; 0 disables the timeout.
- IDX_W, 4, width of the stage index (must satisfy 2^IDX_W >= NUM_STAGES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  launch request; honoured only in IDLE.
- abort  input  1  cancels the run in progress.
- stage_en  input  NUM_STAGES  stage-enable mask, sampled when start is accepted.
- done_in  input  NUM_STAGES  per-stage completion pulses.
- start_out  output  NUM_STAGES  per-stage one-cycle launch pulses (Mealy).
- done  output  1  one-cycle completion pulse (Mealy).
- busy  output  1  high while not in IDLE (registered state decode).
- error  output  1  one-cycle timeout pulse (Mealy).
- err_stage  output  IDX_W  index of the stage that timed out; registered.

Behaviour:
- **States:** IDLE, WAIT(i) for i = 0..NUM_STAGES-1. State, stage index, latched mask, timeout counter and err_stage are all registers.
- **Reset (async, any time, including mid-run):**
  - state = IDLE; counter, mask and err_stage = 0.
  - start_out, done and error are forced to 0 while reset is high.
  - busy = 0.
- **Next-stage search:** nxt(k) is the lowest enabled stage index >= k. It is a purely combinational priority search over the mask.
- **IDLE, start = 1:**
  - Latch stage_en as the mask; clear err_stage.
  - If any bit is set: assert start_out[nxt(0)] in the same cycle and go to WAIT(nxt(0)).
  - If the mask is all zero: assert done in the same cycle and stay in IDLE.
- **WAIT(i), done_in[i] = 1:**
  - If a later enabled stage j = nxt(i+1) exists: assert start_out[j] in the same cycle and go to WAIT(j).
  - Otherwise: assert done in the same cycle and go to IDLE.
- **done_in bits:** bits other than the current stage are ignored at all times. All done_in bits are ignored in IDLE.
- **start while busy:** ignored, with no effect on the mask or the outputs.
- **Timeout counter:**
  - Cleared on every WAIT entry.
  - Increments each WAIT cycle in which done_in[i] = 0.
  - If counter == TIMEOUT_CYCLES-1 and done_in[i] = 0: assert error in that cycle, load err_stage = i, go to IDLE. This is the TIMEOUT_CYCLES-th wait cycle.
  - done_in[i] in that same cycle counts as success; done has priority over timeout.
  - The counter saturates; it never wraps.
  - With TIMEOUT_CYCLES = 0 there is no timeout and error never asserts.
- **Abort:**
  - abort = 1 in WAIT: go to IDLE with no start_out/done/error pulse.
  - Abort has priority over a same-cycle done_in or timeout.
  - abort in IDLE has no effect; abort together with start in IDLE means the start is ignored.
- **Output constraints:**
  - At most one bit of {start_out, done, error} is high in any cycle.
  - Each pulse lasts exactly one cycle per event.
- **Latency:** zero-cycle (Mealy) from the trigger input to its output pulse.
- **Minimum run length:** a run with k enabled stages occupies k WAIT visits; the minimum is one cycle per stage.

Test Plan:
1. **Default sequence** (NUM_STAGES=3, TIMEOUT_CYCLES=16): reset, start with stage_en=3'b111, done_in[0]/[1]/[2] each one cycle after the preceding start_out. Required: start_out[0] in the start cycle, start_out[1] with done_in[0], start_out[2] with done_in[1], done with done_in[2]; busy high from the cycle after start until the cycle after done.
2. **Skip mask:** stage_en=3'b101. Required: start_out[0] in the start cycle, start_out[2] in the done_in[0] cycle, start_out[1] never asserts. A stray done_in[1] is ignored. stage_en=3'b000 produces done in the start cycle and busy stays 0.
3. **Timeout:** stage_en=3'b111, done_in[1] withheld (TIMEOUT_CYCLES=8). Required: error in the 8th cycle after the start_out[1] pulse, err_stage=1, then IDLE with busy=0. A new start clears err_stage to 0.
4. **Boundary:** done_in[1] arrives exactly in the 8th wait cycle. Required: start_out[2] asserts and error stays 0.
5. **Abort and reset:**
   - abort coincident with done_in[0]: no start_out[1], busy=0 next cycle.
   - start while busy: ignored.
   - Async reset asserted mid-WAIT(2) between clock edges: outputs go 0 immediately, and the block is in IDLE after release.

Source files
------------

// File: rtl/melay_seq_n.sv
// melay_seq_n: N-stage Mealy launch/complete sequencer.
// Per-run skip mask, per-stage timeout, synchronous abort.
module melay_seq_n #(
  parameter int NUM_STAGES     = 3,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int IDX_W          = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_en,
  input  logic [NUM_STAGES-1:0] done_in,
  output logic [NUM_STAGES-1:0] start_out,
  output logic                  done,
  output logic                  busy,
  output logic                  error,
  output logic [IDX_W-1:0]      err_stage
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '1;

  logic [0:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      es_q, es_d;

  logic [NUM_STAGES-1:0] so_c;
  logic                  done_c;
  logic                  err_c;
  logic [IDX_W:0]        nxt_start;
  logic [IDX_W:0]        nxt_wait;
  logic                  cur_done;

  // Lowest set bit of m at or above position from; MSB flags a hit.
  function automatic logic [IDX_W:0] find_next(
    input logic [NUM_STAGES-1:0] m,
    input int                    from
  );
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (i >= from && m[i]) begin
        r = {1'b1, IDX_W'(i)};
      end
    end
    return r;
  endfunction

  // Next-state, pulse generation and counter update.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    es_d      = es_q;
    so_c      = '0;
    done_c    = 1'b0;
    err_c     = 1'b0;
    nxt_start = find_next(stage_en, 0);
    nxt_wait  = find_next(mask_q, int'(idx_q) + 1);
    cur_done  = |(done_in & (NUM_STAGES'(1) << idx_q));
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          mask_d = stage_en;
          es_d   = '0;
          if (nxt_start[IDX_W]) begin
            so_c    = NUM_STAGES'(1) << nxt_start[IDX_W-1:0];
            state_d = S_WAIT;
            idx_d   = nxt_start[IDX_W-1:0];
            cnt_d   = '0;
          end else begin
            done_c = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cur_done) begin
          if (nxt_wait[IDX_W]) begin
            so_c  = NUM_STAGES'(1) << nxt_wait[IDX_W-1:0];
            idx_d = nxt_wait[IDX_W-1:0];
            cnt_d = '0;
          end else begin
            done_c  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
          err_c   = 1'b1;
          es_d    = idx_q;
          state_d = S_IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      es_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      es_q    <= es_d;
    end
  end

  // Pulses are gated so they drop the moment reset rises.
  always_comb begin
    start_out = reset ? '0 : so_c;
    done      = done_c & ~reset;
    error     = err_c & ~reset;
  end

  assign busy      = (state_q == S_WAIT);
  assign err_stage = es_q;

endmodule

// File: tb/tb_melay_seq_n.sv
// tb_melay_seq_n: directed table plus hand sequences
// for melay_seq_n with NUM_STAGES=3, TIMEOUT_CYCLES=8.
module tb_melay_seq_n;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [2:0] stage_en;
  logic [2:0] done_in;
  logic [2:0] start_out;
  logic       done;
  logic       busy;
  logic       error;
  logic [3:0] err_stage;

  int checks;
  int errors;

  melay_seq_n #(
    .NUM_STAGES    (3),
    .TIMEOUT_CYCLES(8),
    .IDX_W         (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .stage_en (stage_en),
    .done_in  (done_in),
    .start_out(start_out),
    .done     (done),
    .busy     (busy),
    .error    (error),
    .err_stage(err_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       ab;
    logic [2:0] en;
    logic [2:0] din;
    logic [2:0] so;
    logic       dn;
    logic       er;
    logic       bs;
    logic [3:0] es;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(
    input logic st, input logic ab,
    input logic [2:0] en, input logic [2:0] din,
    input logic [2:0] so, input logic dn,
    input logic er, input logic bs,
    input logic [3:0] es
  );
    vec_t v;
    v.st = st; v.ab = ab; v.en = en; v.din = din;
    v.so = so; v.dn = dn; v.er = er; v.bs = bs;
    v.es = es;
    tbl.push_back(v);
  endfunction

  task automatic check(
    input string nm,
    input logic [9:0] act,
    input logic [9:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got so/dn/er/bs/es=%b want %b",
               nm, act, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {start_out, done, error, busy, err_stage};
  endfunction

  task automatic drive(
    input logic st, input logic ab,
    input logic [2:0] en, input logic [2:0] din
  );
    start = st; abort = ab; stage_en = en; done_in = din;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(0, 0, 3'b000, 3'b000);

    // Default sequence
    add(0,0,3'b000,3'b000, 3'b000,0,0,0,4'd0);
    add(1,0,3'b111,3'b000, 3'b001,0,0,0,4'd0);
    add(0,0,3'b000,3'b001, 3'b010,0,0,1,4'd0);
    add(0,0,3'b000,3'b010, 3'b100,0,0,1,4'd0);
    add(0,0,3'b000,3'b100, 3'b000,1,0,1,4'd0);
    add(0,0,3'b000,3'b000, 3'b000,0,0,0,4'd0);
    // Skip mask, stray done, empty mask, idle done_in
    add(1,0,3'b101,3'b000, 3'b001,0,0,0,4'd0);
    add(0,0,3'b000,3'b010, 3'b000,0,0,1,4'd0);
    add(0,0,3'b000,3'b001, 3'b100,0,0,1,4'd0);
    add(0,0,3'b000,3'b100, 3'b000,1,0,1,4'd0);
    add(1,0,3'b000,3'b000, 3'b000,1,0,0,4'd0);
    add(0,0,3'b000,3'b000, 3'b000,0,0,0,4'd0);
    add(0,0,3'b000,3'b111, 3'b000,0,0,0,4'd0);
    // Timeout on stage 1
    add(1,0,3'b111,3'b000, 3'b001,0,0,0,4'd0);
    add(0,0,3'b000,3'b001, 3'b010,0,0,1,4'd0);
    for (int i = 0; i < 7; i++)
      add(0,0,3'b000,3'b000, 3'b000,0,0,1,4'd0);
    add(0,0,3'b000,3'b000, 3'b000,0,1,1,4'd0);
    add(0,0,3'b000,3'b000, 3'b000,0,0,0,4'd1);
    // New start clears err_stage; done on 8th wait cycle wins
    add(1,0,3'b111,3'b000, 3'b001,0,0,0,4'd1);
    add(0,0,3'b000,3'b001, 3'b010,0,0,1,4'd0);
    for (int i = 0; i < 7; i++)
      add(0,0,3'b000,3'b000, 3'b000,0,0,1,4'd0);
    add(0,0,3'b000,3'b010, 3'b100,0,0,1,4'd0);
    add(0,0,3'b000,3'b100, 3'b000,1,0,1,4'd0);
    add(0,0,3'b000,3'b000, 3'b000,0,0,0,4'd0);
    // Abort with start in IDLE blocks the start
    add(1,1,3'b111,3'b000, 3'b000,0,0,0,4'd0);
    add(0,0,3'b000,3'b000, 3'b000,0,0,0,4'd0);

    #3;
    check("reset_outputs", outs(), 10'b000_0_0_0_0000);
    step();
    reset = 1'b0;

    foreach (tbl[k]) begin
      drive(tbl[k].st, tbl[k].ab, tbl[k].en, tbl[k].din);
      @(negedge clk);
      check($sformatf("vec%0d", k), outs(),
            {tbl[k].so, tbl[k].dn, tbl[k].er,
             tbl[k].bs, tbl[k].es});
      step();
    end

    // Abort coincident with done_in[0]
    drive(1, 0, 3'b111, 3'b000);
    @(negedge clk);
    check("abort_start", outs(), 10'b001_0_0_0_0000);
    step();
    drive(0, 1, 3'b000, 3'b001);
    @(negedge clk);
    check("abort_cycle", outs(), 10'b000_0_0_1_0000);
    step();
    drive(0, 0, 3'b000, 3'b010);
    @(negedge clk);
    check("abort_after", outs(), 10'b000_0_0_0_0000);
    step();

    // Start while busy leaves the latched mask alone
    drive(1, 0, 3'b011, 3'b000);
    @(negedge clk);
    check("busy_start0", outs(), 10'b001_0_0_0_0000);
    step();
    drive(1, 0, 3'b100, 3'b000);
    @(negedge clk);
    check("busy_start1", outs(), 10'b000_0_0_1_0000);
    step();
    drive(0, 0, 3'b000, 3'b001);
    @(negedge clk);
    check("busy_stage1", outs(), 10'b010_0_0_1_0000);
    step();
    drive(0, 0, 3'b000, 3'b010);
    @(negedge clk);
    check("busy_done", outs(), 10'b000_1_0_1_0000);
    step();
    drive(0, 0, 3'b000, 3'b000);
    step();

    // Async reset in the middle of WAIT(2)
    drive(1, 0, 3'b111, 3'b000);
    step();
    drive(0, 0, 3'b000, 3'b001);
    step();
    drive(0, 0, 3'b000, 3'b010);
    step();
    drive(0, 0, 3'b000, 3'b100);
    #1;
    check("rst_pre", outs(), 10'b000_1_0_1_0000);
    #1;
    reset = 1'b1;
    #1;
    check("rst_async", outs(), 10'b000_0_0_0_0000);
    step();
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("rst_idle", outs(), 10'b000_0_0_0_0000);
    step();
    drive(1, 0, 3'b111, 3'b000);
    @(negedge clk);
    check("rst_restart", outs(), 10'b001_0_0_0_0000);
    step();
    drive(0, 0, 3'b000, 3'b000);
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
